// File: rtl/vga_timing_pkg.sv
// Purpose: shared VGA raster timing constants (default 640x480 @ 60 Hz)
// and a small window-test helper. The drawing primitives import the same
// constants so that their notion of the active area matches the generator.
// Ports: none (package).
package vga_timing_pkg;

    localparam int CNT_W = 10;
    typedef logic [CNT_W-1:0] cnt_t;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;
    localparam int CLK_DIV_DEF  = 4;

    localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync windows are half-open: [start, end).
    localparam int HS_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_END_DEF   = HS_START_DEF + H_SYNC_DEF;
    localparam int VS_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_END_DEF   = VS_START_DEF + V_SYNC_DEF;

    // Widen before comparing so a bound of 1024 does not alias to 0.
    function automatic logic in_window(cnt_t v, int lo, int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/pix_tick_gen.sv
// Purpose: divides clk down to the pixel rate. pix_tick is high for one clk
// in every CLK_DIV enabled cycles (continuously high with CLK_DIV=1).
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset (divider -> 0)
//   en       in   run enable; low freezes the divider and forces pix_tick=0
//   pix_tick out  one-clk pulse while the divider sits at CLK_DIV-1
module pix_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic             w_last;

    assign w_last = (r_div == DIV_LAST);

    // Combinational so CLK_DIV=1 yields pix_tick=en; rst masks it so the
    // counters never see a tick while being reset.
    assign pix_tick = en & ~rst & w_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div <= '0;
        end else if (pix_tick) begin
            r_div <= '0;
        end else if (en) begin
            r_div <= r_div + 1'b1;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Purpose: VGA raster timing generator. Produces the pixel tick, x/y
// position counters and registered decode (display, hsync, vsync,
// line_start, frame_start) that always describe the current (x,y).
// Ports:
//   clk, rst, en          clock, synchronous active-high reset, run enable
//   pix_tick              one-clk pixel-rate pulse; counters advance on it
//   x, y                  position 0..H_TOTAL-1 / 0..V_TOTAL-1
//   display               x<H_ACTIVE and y<V_ACTIVE
//   hsync, vsync          syncs, asserted level SYNC_POL
//   line_start            high while x==0
//   frame_start           high while x==0 and y==0
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter int CLK_DIV  = CLK_DIV_DEF,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_tick,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             display,
    output logic             hsync,
    output logic             vsync,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam cnt_t X_LAST = cnt_t'(H_TOTAL - 1);
    localparam cnt_t Y_LAST = cnt_t'(V_TOTAL - 1);

    logic w_tick;
    cnt_t w_x_nxt;
    cnt_t w_y_nxt;
    logic w_display;
    logic w_hsync;
    logic w_vsync;
    logic w_line_start;
    logic w_frame_start;

    cnt_t r_x;
    cnt_t r_y;
    logic r_display;
    logic r_hsync;
    logic r_vsync;
    logic r_line_start;
    logic r_frame_start;

    pix_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .pix_tick (w_tick)
    );

    always_comb begin
        w_x_nxt = r_x;
        w_y_nxt = r_y;
        if (w_tick) begin
            if (r_x == X_LAST) begin
                w_x_nxt = '0;
                w_y_nxt = (r_y == Y_LAST) ? '0 : r_y + 1'b1;
            end else begin
                w_x_nxt = r_x + 1'b1;
            end
        end
    end

    // Decode the position the counters are about to take so the registered
    // flags line up with x/y in the same cycle.
    always_comb begin
        w_display     = (int'(w_x_nxt) < H_ACTIVE) && (int'(w_y_nxt) < V_ACTIVE);
        w_hsync       = in_window(w_x_nxt, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
        w_vsync       = in_window(w_y_nxt, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
        w_line_start  = (w_x_nxt == '0);
        w_frame_start = (w_x_nxt == '0) && (w_y_nxt == '0);
    end

    // Reset parks the raster on the last pixel so the first tick wraps to
    // (0,0) and frame 0 starts complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x           <= X_LAST;
            r_y           <= Y_LAST;
            r_display     <= 1'b0;
            r_hsync       <= ~SYNC_POL;
            r_vsync       <= ~SYNC_POL;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (w_tick) begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_display     <= w_display;
            r_hsync       <= w_hsync;
            r_vsync       <= w_vsync;
            r_line_start  <= w_line_start;
            r_frame_start <= w_frame_start;
        end
    end

    assign pix_tick    = w_tick;
    assign x           = r_x;
    assign y           = r_y;
    assign display     = r_display;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;

endmodule
